// File: rtl/vending_machine_param.sv
// Parametrised vending controller. It accumulates coin credit, sells one of
// N_ITEMS products at per-item prices, and returns change coin by coin over a
// valid/ready handshake.
// Ports:
//   clk, rst          - clock (rising edge), synchronous active-high reset
//   coin_valid, coin  - coin strobe and coin code from the acceptor
//   sel, buy          - product select and purchase request
//   cancel            - refund request
//   change_ready      - dispenser accepts the offered change coin
//   out, out_item     - one-cycle vend pulse and the item vended
//   change_valid      - change coin offered
//   change            - code of the offered change coin
//   credit            - current credit
//   busy              - high while vending or returning change
//   coin_reject       - one-cycle pulse, coin routed to the return chute
module vending_machine_param #(
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned N_ITEMS    = 4,
  parameter int unsigned SEL_W      = 2,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES = {8'd25, 8'd20, 8'd15, 8'd10},
  parameter int unsigned COIN_VAL0  = 5,
  parameter int unsigned COIN_VAL1  = 10,
  parameter int unsigned COIN_VAL2  = 25,
  parameter int unsigned MAX_CREDIT = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin,
  input  logic [SEL_W-1:0]    sel,
  input  logic                buy,
  input  logic                cancel,
  input  logic                change_ready,
  output logic                out,
  output logic [SEL_W-1:0]    out_item,
  output logic                change_valid,
  output logic [1:0]          change,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_reject
);

  localparam int unsigned SUM_W = CREDIT_W + 1;
  localparam logic [CREDIT_W-1:0] VAL0    = CREDIT_W'(COIN_VAL0);
  localparam logic [CREDIT_W-1:0] VAL1    = CREDIT_W'(COIN_VAL1);
  localparam logic [CREDIT_W-1:0] VAL2    = CREDIT_W'(COIN_VAL2);
  localparam logic [SUM_W-1:0]    MAX_SUM = SUM_W'(MAX_CREDIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                out_q, out_d;
  logic [SEL_W-1:0]    out_item_q, out_item_d;
  logic                change_valid_q, change_valid_d;
  logic [1:0]          change_q, change_d;
  logic                busy_q, busy_d;
  logic                coin_reject_q, coin_reject_d;

  // Value of a coin code; the invalid code is worth nothing.
  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      2'b00:   coin_value = VAL0;
      2'b01:   coin_value = VAL1;
      2'b10:   coin_value = VAL2;
      default: coin_value = '0;
    endcase
  endfunction

  // Greedy pick: largest coin not exceeding the remaining credit.
  function automatic logic [1:0] greedy_code(input logic [CREDIT_W-1:0] c);
    if (c >= VAL2)      greedy_code = 2'b10;
    else if (c >= VAL1) greedy_code = 2'b01;
    else                greedy_code = 2'b00;
  endfunction

  logic [SUM_W-1:0]    coin_sum_c;
  logic                coin_ok_c;
  logic [CREDIT_W-1:0] price_c;
  logic                sel_ok_c;
  logic                buy_ok_c;
  logic [CREDIT_W-1:0] remain_c;

  // Price lookup; out-of-range selects fall through with sel_ok_c low.
  always_comb begin
    price_c  = '0;
    sel_ok_c = 1'b0;
    for (int i = 0; i < int'(N_ITEMS); i++) begin
      if (sel == SEL_W'(i)) begin
        price_c  = PRICES[i*CREDIT_W +: CREDIT_W];
        sel_ok_c = 1'b1;
      end
    end
  end

  // Overflow check done one bit wider so the sum can never wrap.
  assign coin_sum_c = {1'b0, credit_q} + {1'b0, coin_value(coin)};
  assign coin_ok_c  = (coin != 2'b11) && (coin_sum_c <= MAX_SUM);
  assign buy_ok_c   = buy && sel_ok_c && (credit_q >= price_c);
  assign remain_c   = credit_q - coin_value(change_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    out_d          = 1'b0;
    out_item_d     = '0;
    change_valid_d = change_valid_q;
    change_d       = change_q;
    coin_reject_d  = 1'b0;

    case (state_q)
      IDLE, CREDIT: begin
        if ((state_q == CREDIT) && cancel) begin
          state_d        = CHANGE;
          change_valid_d = (credit_q >= VAL0);
          change_d       = greedy_code(credit_q);
          coin_reject_d  = coin_valid;
        end else if ((state_q == CREDIT) && buy_ok_c) begin
          state_d       = VEND;
          out_d         = 1'b1;
          out_item_d    = sel;
          credit_d      = credit_q - price_c;
          coin_reject_d = coin_valid;
        end else if (coin_valid) begin
          if (coin_ok_c) begin
            credit_d = coin_sum_c[CREDIT_W-1:0];
            state_d  = CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end

      VEND: begin
        coin_reject_d = coin_valid;
        if (credit_q == '0) begin
          state_d        = IDLE;
          change_valid_d = 1'b0;
        end else begin
          state_d        = CHANGE;
          change_valid_d = (credit_q >= VAL0);
          change_d       = greedy_code(credit_q);
        end
      end

      CHANGE: begin
        coin_reject_d = coin_valid;
        if (!change_valid_q) begin
          // Residual smaller than the smallest coin cannot be paid out.
          state_d        = IDLE;
          credit_d       = '0;
          change_valid_d = 1'b0;
          change_d       = 2'b00;
        end else if (change_ready) begin
          if (remain_c < VAL0) begin
            state_d        = IDLE;
            credit_d       = '0;
            change_valid_d = 1'b0;
            change_d       = 2'b00;
          end else begin
            credit_d       = remain_c;
            change_valid_d = 1'b1;
            change_d       = greedy_code(remain_c);
          end
        end
      end

      default: begin
        state_d        = IDLE;
        credit_d       = '0;
        change_valid_d = 1'b0;
        change_d       = 2'b00;
      end
    endcase

    busy_d = (state_d == VEND) || (state_d == CHANGE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      out_q          <= 1'b0;
      out_item_q     <= '0;
      change_valid_q <= 1'b0;
      change_q       <= 2'b00;
      busy_q         <= 1'b0;
      coin_reject_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      out_q          <= out_d;
      out_item_q     <= out_item_d;
      change_valid_q <= change_valid_d;
      change_q       <= change_d;
      busy_q         <= busy_d;
      coin_reject_q  <= coin_reject_d;
    end
  end

  assign out          = out_q;
  assign out_item     = out_item_q;
  assign change_valid = change_valid_q;
  assign change       = change_q;
  assign credit       = credit_q;
  assign busy         = busy_q;
  assign coin_reject  = coin_reject_q;

endmodule
